// File: rtl/cmd_pkg.sv
// Shared opcode constants, FSM state encoding and decode bundle for the
// command FIFO reader.
package cmd_pkg;

    localparam logic [3:0] OP_WBR = 4'b0000;
    localparam logic [3:0] OP_WBM = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_LATCH = 2'd2,
        ST_EXEC  = 2'd3
    } state_e;

endpackage

// File: rtl/cmd_decode.sv
// Combinational opcode classifier: exactly one of is_wbr / is_wbm / is_bad
// is high for any opcode.
import cmd_pkg::*;

module cmd_decode (
    input  logic [3:0] opcode,
    output logic       is_wbr,
    output logic       is_wbm,
    output logic       is_bad
);

    always_comb begin
        is_wbr = (opcode == OP_WBR);
        is_wbm = (opcode == OP_WBM);
        is_bad = !(is_wbr || is_wbm);
    end

endmodule

// File: rtl/cmd_fifo_reader.sv
// Pops {dataA,dataB} command pairs from a non-show-ahead FIFO and issues
// bank-register / sprite-memory write strobes. `CMD_ERR_COUNT_EN builds the
// saturating unknown-opcode counter.
import cmd_pkg::*;

module cmd_fifo_reader #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rdempty,
    input  logic [31:0]           dataA,
    input  logic [31:0]           dataB,
    input  logic                  ready,
    output logic                  rdreq,
    output logic                  reg_wr,
    output logic [REG_ADDR_W-1:0] reg_addr,
    output logic [31:0]           reg_data,
    output logic                  mem_wr,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [8:0]            mem_data,
    output logic                  busy,
    output logic [7:0]            err_count
);

    state_e                state_q, state_d;
    logic                  rdreq_q, rdreq_d;
    logic                  busy_q, busy_d;
    logic                  reg_wr_q, reg_wr_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [31:0]           cmd_a_q, cmd_a_d;
    logic [31:0]           cmd_b_q, cmd_b_d;
    logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [31:0]           reg_data_q, reg_data_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [8:0]            mem_data_q, mem_data_d;
    logic                  exec_fire;
    logic                  is_wbr, is_wbm, is_bad;

    cmd_decode u_decode (
        .opcode (cmd_a_q[3:0]),
        .is_wbr (is_wbr),
        .is_wbm (is_wbm),
        .is_bad (is_bad)
    );

    always_comb begin
        state_d    = state_q;
        cmd_a_d    = cmd_a_q;
        cmd_b_d    = cmd_b_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        reg_wr_d   = 1'b0;
        mem_wr_d   = 1'b0;
        exec_fire  = 1'b0;

        case (state_q)
            ST_IDLE:  if (!rdempty) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_LATCH;
            // Non-show-ahead FIFO: the popped words appear the cycle after rdreq.
            ST_LATCH: begin
                cmd_a_d = dataA;
                cmd_b_d = dataB;
                state_d = ST_EXEC;
            end
            ST_EXEC: if (ready) begin
                exec_fire = 1'b1;
                state_d   = ST_IDLE;
                reg_wr_d  = is_wbr;
                mem_wr_d  = is_wbm;
                if (is_wbr) begin
                    reg_addr_d = cmd_a_q[4 +: REG_ADDR_W];
                    reg_data_d = cmd_b_q;
                end
                if (is_wbm) begin
                    mem_addr_d = cmd_a_q[4 +: MEM_ADDR_W];
                    mem_data_d = cmd_b_q[8:0];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered outputs follow the state being entered.
        rdreq_d = (state_d == ST_FETCH);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rdreq_q    <= 1'b0;
            busy_q     <= 1'b0;
            reg_wr_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            cmd_a_q    <= '0;
            cmd_b_q    <= '0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rdreq_q    <= rdreq_d;
            busy_q     <= busy_d;
            reg_wr_q   <= reg_wr_d;
            mem_wr_q   <= mem_wr_d;
            cmd_a_q    <= cmd_a_d;
            cmd_b_q    <= cmd_b_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

`ifdef CMD_ERR_COUNT_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (exec_fire && is_bad && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) err_q <= '0;
        else       err_q <= err_d;
    end

    assign err_count = err_q;

    logic unused_bits;
    assign unused_bits = ^cmd_a_q;
`else
    assign err_count = '0;

    logic unused_bits;
    assign unused_bits = ^{cmd_a_q, is_bad, exec_fire};
`endif

    assign rdreq    = rdreq_q;
    assign busy     = busy_q;
    assign reg_wr   = reg_wr_q;
    assign mem_wr   = mem_wr_q;
    assign reg_addr = reg_addr_q;
    assign reg_data = reg_data_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;

endmodule

// File: tb/tb_cmd_fifo_reader.sv
// Randomised bench for cmd_fifo_reader with a transaction-level timing model
// and a queue-based non-show-ahead FIFO. Honours `CMD_ERR_COUNT_EN.
module tb_cmd_fifo_reader;

    localparam int RW  = 5;
    localparam int MW  = 14;
    localparam int BIG = 32'h7fff_ffff;

    logic          clk;
    logic          reset;
    logic          rdempty;
    logic [31:0]   dataA;
    logic [31:0]   dataB;
    logic          ready;
    logic          rdreq;
    logic          reg_wr;
    logic [RW-1:0] reg_addr;
    logic [31:0]   reg_data;
    logic          mem_wr;
    logic [MW-1:0] mem_addr;
    logic [8:0]    mem_data;
    logic          busy;
    logic [7:0]    err_count;

    cmd_fifo_reader #(
        .REG_ADDR_W (RW),
        .MEM_ADDR_W (MW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rdempty   (rdempty),
        .dataA     (dataA),
        .dataB     (dataB),
        .ready     (ready),
        .rdreq     (rdreq),
        .reg_wr    (reg_wr),
        .reg_addr  (reg_addr),
        .reg_data  (reg_data),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .busy      (busy),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    int ready_mode = 0;
    int push_pct   = 0;
    int rst_permil = 0;
    int rst_hold   = 3;

    int cyc = 0;
    bit chk_en = 0;
    int idle_from = 0;
    int fetch_cyc = -1;
    int exec_from = BIG;
    int strobe_cyc = -1;
    logic [31:0] cur_a, cur_b;
    logic [RW-1:0] e_raddr;
    logic [31:0]   e_rdata;
    logic [MW-1:0] e_maddr;
    logic [8:0]    e_mdata;
    logic [7:0]    e_err;
    bit rdreq_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [31:0] a_in, input logic [31:0] b_in);
        logic [31:0] a;
        a = a_in;
        a[3:0] = op;
        q_a.push_back(a);
        q_b.push_back(b_in);
        rdempty = 1'b0;
    endtask

    task automatic push_rand();
        int r;
        logic [3:0] op;
        r = $urandom_range(9, 0);
        if (r < 4)      op = 4'h0;
        else if (r < 8) op = 4'h1;
        else            op = 4'($urandom_range(15, 2));
        push_cmd(op, $urandom, $urandom);
    endtask

    task automatic step();
        logic [3:0] op;
        @(negedge clk);
        // Effects that become visible in this cycle.
        if (cyc == strobe_cyc) begin
            op = cur_a[3:0];
            if (op == 4'h0) begin
                e_raddr = cur_a[4 +: RW];
                e_rdata = cur_b;
            end else if (op == 4'h1) begin
                e_maddr = cur_a[4 +: MW];
                e_mdata = cur_b[8:0];
            end else begin
`ifdef CMD_ERR_COUNT_EN
                if (e_err != 8'hFF) e_err = e_err + 8'd1;
`endif
            end
        end
        if (chk_en) begin
            op = cur_a[3:0];
            chk("rdreq",     32'(rdreq),     32'(cyc == fetch_cyc));
            chk("busy",      32'(busy),      32'(cyc < idle_from));
            chk("reg_wr",    32'(reg_wr),    32'((cyc == strobe_cyc) && (op == 4'h0)));
            chk("mem_wr",    32'(mem_wr),    32'((cyc == strobe_cyc) && (op == 4'h1)));
            chk("reg_addr",  32'(reg_addr),  32'(e_raddr));
            chk("reg_data",  reg_data,       e_rdata);
            chk("mem_addr",  32'(mem_addr),  32'(e_maddr));
            chk("mem_data",  32'(mem_data),  32'(e_mdata));
            chk("err_count", 32'(err_count), 32'(e_err));
        end
        // Decide what the inputs of this cycle cause.
        if (reset) begin
            chk_en = 1;
            idle_from = cyc + 1;
            fetch_cyc = -1;
            exec_from = BIG;
            strobe_cyc = -1;
            e_raddr = '0; e_rdata = '0; e_maddr = '0; e_mdata = '0; e_err = '0;
        end else if (cyc >= idle_from && !rdempty) begin
            cur_a = q_a[0];
            cur_b = q_b[0];
            fetch_cyc = cyc + 1;
            exec_from = cyc + 3;
            idle_from = BIG;
        end else if (idle_from == BIG && cyc >= exec_from && ready) begin
            strobe_cyc = cyc + 1;
            idle_from = cyc + 1;
        end
        rdreq_seen = rdreq;
        @(posedge clk);
        #1;
        cyc++;
        // FIFO read side: popped word is presented only in the cycle after rdreq.
        if (rdreq_seen) begin
            chk("no_underflow", 32'(q_a.size() == 0), 32'd0);
            if (q_a.size() != 0) begin
                dataA = q_a.pop_front();
                dataB = q_b.pop_front();
            end
        end else begin
            dataA = $urandom;
            dataB = $urandom;
        end
        if (push_pct > 0 && $urandom_range(99, 0) < push_pct) push_rand();
        rdempty = (q_a.size() == 0);
        case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = 1'($urandom_range(1, 0));
        endcase
        if (rst_hold > 0) begin
            reset = 1'b1;
            rst_hold--;
        end else begin
            reset = (rst_permil > 0) && ($urandom_range(999, 0) < rst_permil);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        reset = 1'b1; rdempty = 1'b1; ready = 1'b0; dataA = '0; dataB = '0;
        cur_a = '0; cur_b = '0;
        e_raddr = '0; e_rdata = '0; e_maddr = '0; e_mdata = '0; e_err = '0;
        run(6);

        ready_mode = 1;
        push_cmd(4'h0, 32'h0000_0050, 32'hDEAD_BEEF);
        run(10);
        push_cmd(4'h1, 32'h0001_2341, 32'h0000_01FF);
        run(10);

        ready_mode = 0;
        push_cmd(4'h0, 32'h0000_01A0, 32'h1234_5678);
        run(16);
        ready_mode = 1;
        run(6);

        push_cmd(4'h0, 32'h0000_0030, 32'hAAAA_5555);
        push_cmd(4'h1, 32'h0000_ABC1, 32'h0000_0123);
        push_cmd(4'h0, 32'h0000_01F0, 32'h0F0F_F0F0);
        run(20);

        for (int i = 0; i < 300; i++) push_cmd(4'hF, $urandom, $urandom);
        run(1220);

        ready_mode = 0;
        push_cmd(4'h0, 32'h0000_0070, 32'hCAFE_0001);
        push_cmd(4'h1, 32'h0000_7771, 32'h0000_0042);
        for (int i = 0; i < 20 && !(idle_from == BIG && cyc >= exec_from); i++) step();
        run(3);
        rst_hold = 1;
        run(2);
        ready_mode = 1;
        run(12);

        ready_mode = 2;
        push_pct   = 15;
        rst_permil = 4;
        run(3000);

        push_pct   = 0;
        rst_permil = 0;
        ready_mode = 1;
        for (int i = 0; i < 4000 && q_a.size() != 0; i++) step();
        run(8);
        chk("fifo_drained", 32'(q_a.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
